// File: rtl/regfile_pkg.sv
// Shared constants and types for the two-slot VLIW register file.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: mux over the storage array.
// With REGFILE_BYPASS_EN defined, same-cycle write data is forwarded (ALU over mem).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  localparam int NREGS = 2 ** ADDR_W
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                         rst_n,
  input  logic                         mem_we,
  input  logic [ADDR_W-1:0]            mem_wa,
  input  logic [DATA_W-1:0]            mem_wd,
  input  logic                         alu_we,
  input  logic [ADDR_W-1:0]            alu_wa,
  input  logic [DATA_W-1:0]            alu_wd,
`endif
  output logic [DATA_W-1:0]            data
);

  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // ALU checked last so it wins a shared-address hit, matching the write conflict rule
    if (rst_n) begin
      if (mem_we && (mem_wa == addr)) data = mem_wd;
      if (alu_we && (alu_wa == addr)) data = alu_wd;
    end
`endif
  end

endmodule

// File: rtl/vliw_register_file.sv
// 8x32 register file, two write ports (mem, ALU) and four combinational read ports.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on all reads.
module vliw_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_regWrite,
  input  logic [ADDR_W-1:0] mem_rn,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_writeData,
  input  logic              alu_regWrite,
  input  logic [ADDR_W-1:0] alu_rn,
  input  logic [ADDR_W-1:0] alu_rm,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_writeData,
  output logic [DATA_W-1:0] mem_reg_rn,
  output logic [DATA_W-1:0] mem_reg_rd,
  output logic [DATA_W-1:0] alu_reg_rn,
  output logic [DATA_W-1:0] alu_reg_rm
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int NRP   = 4;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NRP-1:0][ADDR_W-1:0]   rp_addr;
  logic [NRP-1:0][DATA_W-1:0]   rp_data;

  // ALU write is issued second so it overwrites the mem write on an address clash
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else begin
      if (mem_regWrite) regs[mem_rd] <= mem_writeData;
      if (alu_regWrite) regs[alu_rd] <= alu_writeData;
    end
  end

  assign rp_addr = {alu_rm, alu_rn, mem_rd, mem_rn};

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp (
      .regs   (regs),
      .addr   (rp_addr[p]),
`ifdef REGFILE_BYPASS_EN
      .rst_n  (reset),
      .mem_we (mem_regWrite),
      .mem_wa (mem_rd),
      .mem_wd (mem_writeData),
      .alu_we (alu_regWrite),
      .alu_wa (alu_rd),
      .alu_wd (alu_writeData),
`endif
      .data   (rp_data[p])
    );
  end

  assign mem_reg_rn = rp_data[0];
  assign mem_reg_rd = rp_data[1];
  assign alu_reg_rn = rp_data[2];
  assign alu_reg_rm = rp_data[3];

endmodule

// File: tb/tb_vliw_register_file.sv
// Scoreboard bench for vliw_register_file; honours REGFILE_BYPASS_EN for read-during-write.
module tb_vliw_register_file;
  import regfile_pkg::*;

  typedef struct {
    string     name;
    int        port;
    reg_data_t exp;
  } sb_t;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  logic      mem_regWrite = 1'b0, alu_regWrite = 1'b0;
  reg_addr_t mem_rn = '0, mem_rd = '0, alu_rn = '0, alu_rm = '0, alu_rd = '0;
  reg_data_t mem_writeData = '0, alu_writeData = '0;
  reg_data_t mem_reg_rn, mem_reg_rd, alu_reg_rn, alu_reg_rm;

  sb_t  sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic smp = 1'b0;

  vliw_register_file dut (
    .clk(clk), .reset(reset),
    .mem_regWrite(mem_regWrite), .mem_rn(mem_rn), .mem_rd(mem_rd), .mem_writeData(mem_writeData),
    .alu_regWrite(alu_regWrite), .alu_rn(alu_rn), .alu_rm(alu_rm), .alu_rd(alu_rd),
    .alu_writeData(alu_writeData),
    .mem_reg_rn(mem_reg_rn), .mem_reg_rd(mem_reg_rd), .alu_reg_rn(alu_reg_rn), .alu_reg_rm(alu_reg_rm)
  );

  always #5 clk = ~clk;

  // Inputs change 2ns after a rising edge; samples land 3-4ns after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input reg_addr_t a, input reg_addr_t b, input reg_addr_t c, input reg_addr_t d);
    mem_rn = a; mem_rd = b; alu_rn = c; alu_rm = d;
  endtask

  task automatic idle();
    mem_regWrite = 1'b0; alu_regWrite = 1'b0;
  endtask

  task automatic expect4(input string nm, input reg_data_t e0, input reg_data_t e1,
                         input reg_data_t e2, input reg_data_t e3);
    sb_q.push_back('{name: nm, port: 0, exp: e0});
    sb_q.push_back('{name: nm, port: 1, exp: e1});
    sb_q.push_back('{name: nm, port: 2, exp: e2});
    sb_q.push_back('{name: nm, port: 3, exp: e3});
    #1 smp = 1'b1;
    #1 smp = 1'b0;
  endtask

  initial begin : monitor
    sb_t       e;
    reg_data_t act;
    forever begin
      @(posedge smp);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.port)
          0:       act = mem_reg_rn;
          1:       act = mem_reg_rd;
          2:       act = alu_reg_rn;
          default: act = alu_reg_rm;
        endcase
        vec_cnt++;
        if (act !== e.exp) begin
          err_cnt++;
          $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout, bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reg_data_t rdw_exp, clash_exp;
`ifdef REGFILE_BYPASS_EN
    rdw_exp   = 32'h20;
    clash_exp = 32'h2;
`else
    rdw_exp   = 32'h10;
    clash_exp = 32'h0;
`endif
    // Reset held: writes attempted on live edges must be dropped
    #2;
    set_rd(3'd7, 3'd3, 3'd5, 3'd1);
    mem_regWrite = 1'b1; mem_writeData = 32'hAAAA_5555;
    alu_regWrite = 1'b1; alu_rd = 3'd5; alu_writeData = 32'h1234_5678;
    expect4("rst_hold", 0, 0, 0, 0);
    step(); step();
    expect4("rst_hold_edges", 0, 0, 0, 0);
    idle();
    reset = 1'b1;
    expect4("rst_release_a", 0, 0, 0, 0);
    set_rd(3'd0, 3'd2, 3'd4, 3'd6);
    expect4("rst_release_b", 0, 0, 0, 0);

    // Independent dual write on the first edge after release
    mem_regWrite = 1'b1; mem_rd = 3'd4; mem_writeData = 32'h102;
    alu_regWrite = 1'b1; alu_rd = 3'd1; alu_writeData = 32'h4;
    step(); idle();
    set_rd(3'd4, 3'd4, 3'd1, 3'd1);
    expect4("dual_write", 32'h102, 32'h102, 32'h4, 32'h4);

    // Same destination: ALU data must survive
    mem_regWrite = 1'b1; mem_rd = 3'd3; mem_writeData = 32'h100;
    alu_regWrite = 1'b1; alu_rd = 3'd3; alu_writeData = 32'h8;
    step(); idle();
    set_rd(3'd3, 3'd3, 3'd3, 3'd4);
    expect4("conflict", 32'h8, 32'h8, 32'h8, 32'h102);

    // Disabled ALU port with live address/data
    alu_rd = 3'd2; alu_writeData = 32'hDEAD_BEEF;
    set_rd(3'd2, 3'd2, 3'd2, 3'd2);
    expect4("gate_during", 0, 0, 0, 0);
    step();
    expect4("gate_after", 0, 0, 0, 0);

    // Read-during-write on r5
    mem_regWrite = 1'b1; mem_rd = 3'd5; mem_writeData = 32'h10;
    step(); idle();
    set_rd(3'd5, 3'd0, 3'd5, 3'd5);
    alu_regWrite = 1'b1; alu_rd = 3'd5; alu_writeData = 32'h20;
    expect4("rdw_during", rdw_exp, 0, rdw_exp, rdw_exp);
    step(); idle();
    expect4("rdw_after", 32'h20, 0, 32'h20, 32'h20);

    // Same-cycle clash on r6 seen through the read ports
    set_rd(3'd6, 3'd6, 3'd6, 3'd6);
    mem_regWrite = 1'b1; mem_writeData = 32'h1;
    alu_regWrite = 1'b1; alu_rd = 3'd6; alu_writeData = 32'h2;
    expect4("clash_during", clash_exp, clash_exp, clash_exp, clash_exp);
    step(); idle();
    expect4("clash_after", 32'h2, 32'h2, 32'h2, 32'h2);

    // Fill r0..r7 with 0x11..0x88, two per cycle
    for (int i = 0; i < 4; i++) begin
      mem_regWrite = 1'b1; mem_rd = reg_addr_t'(2*i);   mem_writeData = reg_data_t'(32'h11 * (2*i + 1));
      alu_regWrite = 1'b1; alu_rd = reg_addr_t'(2*i+1); alu_writeData = reg_data_t'(32'h11 * (2*i + 2));
      step();
    end
    idle();
    set_rd(3'd0, 3'd7, 3'd3, 3'd4);
    expect4("fill_a", 32'h11, 32'h88, 32'h44, 32'h55);
    set_rd(3'd1, 3'd2, 3'd5, 3'd6);
    expect4("fill_b", 32'h22, 32'h33, 32'h66, 32'h77);

    // Async reset between edges: outputs clear with no clock edge
    reset = 1'b0;
    expect4("mid_reset", 0, 0, 0, 0);
    set_rd(3'd0, 3'd7, 3'd3, 3'd4);
    expect4("mid_reset_b", 0, 0, 0, 0);
    step();
    reset = 1'b1;
    expect4("post_reset", 0, 0, 0, 0);

    #5;
    if (sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
